// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Define ARB_STARVE_GUARD_EN to bound how many data grants can lock out a waiting fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY = 2'd2;
  localparam logic [1:0] ST_TURN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic              i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              m_req_q, m_req_d, m_rw_q, m_rw_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [1:0]        m_size_q, m_size_d;
  logic              force_i, grant_i, grant_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] streak_q, streak_d;
  // Once data has won MAX_D_STREAK times in a row against a waiting fetch, fetch goes next.
  assign force_i = (streak_q == 4'(MAX_D_STREAK)) && i_req && d_req;
`else
  assign force_i = 1'b0;
`endif

  assign grant_d = (state_q == ST_IDLE) && d_req && !force_i;
  assign grant_i = (state_q == ST_IDLE) && i_req && !grant_d;

  always_comb begin
    state_d   = state_q;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    m_req_d   = m_req_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d   = ST_D_BUSY;
          d_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          m_rw_d    = d_rw;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_size_d  = d_size;
        end else if (grant_i) begin
          state_d   = ST_I_BUSY;
          i_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          m_rw_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_size_d  = 2'd2;
        end
      end
      ST_I_BUSY, ST_D_BUSY: begin
        if (m_ack) begin
          state_d = ST_TURN;
          m_req_d = 1'b0;
          m_rw_d  = 1'b0;
          if (state_q == ST_I_BUSY) begin
            i_valid_d = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!m_rw_q) d_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ARB_STARVE_GUARD_EN
  always_comb begin
    streak_d = streak_q;
    if (grant_d)      streak_d = i_req ? streak_q + 4'd1 : 4'd0;
    else if (grant_i) streak_d = 4'd0;
  end

  always_ff @(posedge clock) begin
    if (!reset) streak_q <= 4'd0;
    else        streak_q <= streak_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_req_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign m_req     = m_req_q;
  assign m_rw      = m_rw_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_size    = m_size_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/load, contention, streak guard, reset abort.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rw, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic        i_gnt, i_valid, d_gnt, d_valid, m_req, m_rw;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_ack(m_ack), .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled at the falling edge, half a cycle from the active edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_rw = 0; m_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0; m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step(); step();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    do_reset();
    n_checks++;
    if ({i_gnt, d_gnt, i_valid, d_valid, m_req, m_rw} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 000000", {i_gnt, d_gnt, i_valid, d_valid, m_req, m_rw});
    end
    n_checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata, m_size} !== 130'b0) begin
      n_fail++; $display("FAIL reset_data: m_addr %h m_wdata %h i_rdata %h d_rdata %h m_size %0d exp all 0",
                         m_addr, m_wdata, i_rdata, d_rdata, m_size);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state);
    end
  endtask

  task automatic test_lone_fetch();
    do_reset();
    i_req = 1; i_addr = 32'h0100_0000; m_ack = 1; m_rdata = 32'h0050_0093;
    step(); // edge k: grant
    n_checks++;
    if ({i_gnt, m_req, m_rw, d_gnt} !== 4'b1100) begin
      n_fail++; $display("FAIL fetch_gnt: i_gnt/m_req/m_rw/d_gnt got %b exp 1100", {i_gnt, m_req, m_rw, d_gnt});
    end
    n_checks++;
    if (m_addr !== 32'h0100_0000 || m_size !== 2'd2) begin
      n_fail++; $display("FAIL fetch_maddr: m_addr %h m_size %0d exp 01000000 2", m_addr, m_size);
    end
    step(); // edge k+1: ack
    n_checks++;
    if (i_valid !== 1'b1 || i_rdata !== 32'h0050_0093) begin
      n_fail++; $display("FAIL fetch_valid: i_valid %b i_rdata %h exp 1 00500093", i_valid, i_rdata);
    end
    n_checks++;
    if ({i_gnt, m_req} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_done_ctrl: i_gnt/m_req got %b exp 00", {i_gnt, m_req});
    end
    step(); // edge k+2: TURN, no grant even though i_req is still high
    n_checks++;
    if ({i_gnt, i_valid, m_req} !== 3'b000) begin
      n_fail++; $display("FAIL fetch_turn: i_gnt/i_valid/m_req got %b exp 000", {i_gnt, i_valid, m_req});
    end
    step(); // edge k+3: earliest next grant
    n_checks++;
    if (i_gnt !== 1'b1) begin
      n_fail++; $display("FAIL fetch_regrant: i_gnt got %b exp 1", i_gnt);
    end
    i_req = 0;
    step(); step(); step();
    n_checks++;
    if (dbg_state !== 2'd0 || i_rdata !== 32'h0050_0093) begin
      n_fail++; $display("FAIL fetch_idle: state %0d i_rdata %h exp 0 00500093", dbg_state, i_rdata);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    m_ack = 1; m_rdata = 32'h1234_5678;
    d_req = 1; d_rw = 1; d_addr = 32'h0100_0100; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    step();
    n_checks++;
    if ({d_gnt, i_gnt, m_req, m_rw} !== 4'b1011) begin
      n_fail++; $display("FAIL store_gnt: d_gnt/i_gnt/m_req/m_rw got %b exp 1011", {d_gnt, i_gnt, m_req, m_rw});
    end
    n_checks++;
    if (m_addr !== 32'h0100_0100 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'd2) begin
      n_fail++; $display("FAIL store_mfields: m_addr %h m_wdata %h m_size %0d exp 01000100 deadbeef 2",
                         m_addr, m_wdata, m_size);
    end
    step();
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL store_valid: d_valid %b d_rdata %h exp 1 00000000", d_valid, d_rdata);
    end
    n_checks++;
    if ({m_req, m_rw} !== 2'b00) begin
      n_fail++; $display("FAIL store_done: m_req/m_rw got %b exp 00", {m_req, m_rw});
    end
    // Replace the request with a load during the valid cycle.
    d_rw = 0; d_wdata = 32'h0; d_size = 2'd2; m_rdata = 32'hDEAD_BEEF;
    step(); // TURN
    n_checks++;
    if ({d_gnt, d_valid} !== 2'b00) begin
      n_fail++; $display("FAIL load_turn: d_gnt/d_valid got %b exp 00", {d_gnt, d_valid});
    end
    step();
    n_checks++;
    if ({d_gnt, m_req, m_rw} !== 3'b110 || m_addr !== 32'h0100_0100) begin
      n_fail++; $display("FAIL load_gnt: d_gnt/m_req/m_rw %b m_addr %h exp 110 01000100", {d_gnt, m_req, m_rw}, m_addr);
    end
    step();
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_valid: d_valid %b d_rdata %h exp 1 deadbeef", d_valid, d_rdata);
    end
    d_req = 0;
    step(); step(); step();
    n_checks++;
    if (d_rdata !== 32'hDEAD_BEEF || d_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_hold: d_rdata %h d_valid %b exp deadbeef 0", d_rdata, d_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    m_ack = 0; m_rdata = 32'hA5A5_0001;
    i_req = 1; i_addr = 32'h0000_4000;
    d_req = 1; d_rw = 0; d_addr = 32'h0000_8000; d_size = 2'd1;
    step();
    n_checks++;
    if ({d_gnt, i_gnt} !== 2'b10 || m_addr !== 32'h0000_8000 || m_size !== 2'd1) begin
      n_fail++; $display("FAIL tie_dfirst: d_gnt/i_gnt %b m_addr %h m_size %0d exp 10 00008000 1",
                         {d_gnt, i_gnt}, m_addr, m_size);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({m_req, d_gnt, i_gnt, d_valid} !== 4'b1000 || m_addr !== 32'h0000_8000) begin
        n_fail++; $display("FAIL tie_wait%0d: m_req/d_gnt/i_gnt/d_valid %b m_addr %h exp 1000 00008000",
                           c, {m_req, d_gnt, i_gnt, d_valid}, m_addr);
      end
    end
    m_ack = 1;
    step();
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hA5A5_0001 || i_gnt !== 1'b0) begin
      n_fail++; $display("FAIL tie_dvalid: d_valid %b d_rdata %h i_gnt %b exp 1 a5a50001 0", d_valid, d_rdata, i_gnt);
    end
    d_req = 0; m_ack = 0; m_rdata = 32'h0000_0013;
    step(); // TURN
    n_checks++;
    if (i_gnt !== 1'b0) begin
      n_fail++; $display("FAIL tie_turn: i_gnt got %b exp 0", i_gnt);
    end
    step();
    n_checks++;
    if (i_gnt !== 1'b1 || m_addr !== 32'h0000_4000 || m_size !== 2'd2 || m_rw !== 1'b0) begin
      n_fail++; $display("FAIL tie_igrant: i_gnt %b m_addr %h m_size %0d m_rw %b exp 1 00004000 2 0",
                         i_gnt, m_addr, m_size, m_rw);
    end
    m_ack = 1;
    step();
    n_checks++;
    if (i_valid !== 1'b1 || i_rdata !== 32'h0000_0013) begin
      n_fail++; $display("FAIL tie_ivalid: i_valid %b i_rdata %h exp 1 00000013", i_valid, i_rdata);
    end
    i_req = 0;
    step(); step();
  endtask

  task automatic test_streak_guard();
    logic exp_d[10];
    `ifdef ARB_STARVE_GUARD_EN
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    `else
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    `endif
    do_reset();
    m_ack = 1; m_rdata = 32'h0;
    i_req = 1; i_addr = 32'h0000_0100;
    d_req = 1; d_rw = 0; d_addr = 32'h0000_0200; d_size = 2'd2;
    for (int g = 0; g < 10; g++) begin
      int waited;
      waited = 0;
      step();
      while (!(i_gnt || d_gnt) && waited < 6) begin
        step();
        waited++;
      end
      n_checks++;
      if (!(i_gnt || d_gnt)) begin
        n_fail++; $display("FAIL streak_timeout%0d: no grant within 6 cycles", g);
      end else if (d_gnt !== exp_d[g] || i_gnt !== !exp_d[g]) begin
        n_fail++; $display("FAIL streak_grant%0d: d_gnt/i_gnt got %b%b exp %b%b", g, d_gnt, i_gnt, exp_d[g], !exp_d[g]);
      end
    end
    i_req = 0; d_req = 0;
    step(); step(); step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    m_ack = 0; m_rdata = 32'hFFFF_FFFF;
    d_req = 1; d_rw = 1; d_addr = 32'h0000_0300; d_wdata = 32'h1111_2222; d_size = 2'd2;
    step();
    n_checks++;
    if (dbg_state !== 2'd2 || m_req !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy: state %0d m_req %b exp 2 1", dbg_state, m_req);
    end
    reset = 0;
    step();
    n_checks++;
    if (dbg_state !== 2'd0 || {m_req, m_rw, d_valid, d_gnt} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_reset: state %0d m_req/m_rw/d_valid/d_gnt %b exp 0 0000",
                         dbg_state, {m_req, m_rw, d_valid, d_gnt});
    end
    n_checks++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_size !== 2'd0) begin
      n_fail++; $display("FAIL abort_mfields: m_addr %h m_wdata %h m_size %0d exp 0 0 0", m_addr, m_wdata, m_size);
    end
    reset = 1; d_req = 0; m_ack = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({d_valid, i_valid, m_req} !== 3'b000 || dbg_state !== 2'd0 || d_rdata !== 32'h0) begin
        n_fail++; $display("FAIL abort_late_ack%0d: d_valid/i_valid/m_req %b state %0d d_rdata %h exp 000 0 0",
                           c, {d_valid, i_valid, m_req}, dbg_state, d_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_streak_guard();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
